// File: rtl/sram_pkg.sv
// Shared types for the two-port SRAM arbiter: default widths, arbiter FSM
// states and the read-tag record that follows each read through the SRAM
// latency window.
package sram_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One entry per accepted read: valid marks a real read, id names the
  // requester that should receive the returned data.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Read-tag delay line: carries {valid,id} of each accepted read so it emerges
// exactly DEPTH cycles later, lined up with the SRAM read return.
// Ports: a_clk/a_rst (sync, active-high), tag_i (inserted every cycle), tag_o (oldest entry).
module sram_rd_tag_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    a_clk,
  input  logic    a_rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-command SRAM core: registers the
// winner's command, pulses the winner's ready on SRAM accept, and routes read
// returns back to the issuing requester using a latency-matched tag pipeline.
// Ports: a_clk/a_rst (sync, active-high); m0_*/m1_* requester side
// (req/ready handshake, rd/addr/be/wr_data command, rd_data_vld/rd_data return);
// sram_* command/return to the SRAM core; grant_id owner of current/last
// command; orphan_err sticky flag for read data with no outstanding tag.
// Build option: SRAM_ARB_FIXED_PRIO_EN makes port 0 win every contention;
// without it the two ports alternate under contention.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 4
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              m0_req,
  output logic              m0_ready,
  input  logic              m0_rd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_be,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_rd_data_vld,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  output logic              m1_ready,
  input  logic              m1_rd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_be,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_rd_data_vld,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              sram_req,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [1:0]        sram_be,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic              sram_ready,
  input  logic              sram_rd_data_vld,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              grant_id,
  output logic              orphan_err
);

  arb_state_e        state_q, state_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        be_q, be_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              grant_q, grant_d;
  logic              orphan_q, orphan_d;
  logic              win;
  logic              accept;
  rd_tag_t           tag_in, tag_out;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Port 0 always wins; port 1 only when port 0 is quiet.
  assign win = ~m0_req;
`else
  logic last_grant_q, last_grant_d;

  // Under contention hand the slot to whoever did not get the last one.
  always_comb begin
    win = m1_req;
    if (m0_req && m1_req) begin
      win = ~last_grant_q;
    end
  end
`endif

  // sram_req is exactly "in BUSY", so accept needs no extra qualification
  // beyond the BUSY state.
  assign accept = (state_q == BUSY) && sram_ready;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wr_data_d = wr_data_q;
    grant_d   = grant_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d   = BUSY;
          grant_d   = win;
          rd_d      = win ? m1_rd      : m0_rd;
          addr_d    = win ? m1_addr    : m0_addr;
          be_d      = win ? m1_be      : m0_be;
          wr_data_d = win ? m1_wr_data : m0_wr_data;
`ifndef SRAM_ARB_FIXED_PRIO_EN
          last_grant_d = win;
`endif
        end
      end
      BUSY: begin
        // Command fields hold; requester inputs are not looked at here.
        if (sram_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Returns arriving with no tag are dropped and flagged until reset.
  assign orphan_d = orphan_q | (sram_rd_data_vld & ~tag_out.valid);

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wr_data_q <= '0;
      grant_q   <= 1'b0;
      orphan_q  <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wr_data_q <= wr_data_d;
      grant_q   <= grant_d;
      orphan_q  <= orphan_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Only accepted reads enter the tag pipe; writes leave an empty slot.
  assign tag_in.valid = accept & rd_q;
  assign tag_in.id    = grant_q;

  sram_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .a_clk (a_clk),
    .a_rst (a_rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign sram_req     = (state_q == BUSY);
  assign sram_rd      = rd_q;
  assign sram_addr    = addr_q;
  assign sram_be      = be_q;
  assign sram_wr_data = wr_data_q;
  assign grant_id     = grant_q;
  assign orphan_err   = orphan_q;

  assign m0_ready = accept & ~grant_q;
  assign m1_ready = accept &  grant_q;

  assign m0_rd_data_vld = sram_rd_data_vld & tag_out.valid & ~tag_out.id;
  assign m1_rd_data_vld = sram_rd_data_vld & tag_out.valid &  tag_out.id;
  assign m0_rd_data     = sram_rd_data;
  assign m1_rd_data     = sram_rd_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected commands,
// ready pulses and read returns into queues; a negedge monitor pops and
// compares whenever the DUT or the SRAM model presents an event.
module tb_sram_arbiter;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int RDL = 4;

  logic a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  logic          a_rst;
  logic          m0_req, m0_ready, m0_rd, m0_rd_data_vld;
  logic [AW-1:0] m0_addr;
  logic [1:0]    m0_be;
  logic [DW-1:0] m0_wr_data, m0_rd_data;
  logic          m1_req, m1_ready, m1_rd, m1_rd_data_vld;
  logic [AW-1:0] m1_addr;
  logic [1:0]    m1_be;
  logic [DW-1:0] m1_wr_data, m1_rd_data;
  logic          sram_req, sram_rd, sram_ready, sram_rd_data_vld, grant_id, orphan_err;
  logic [AW-1:0] sram_addr;
  logic [1:0]    sram_be;
  logic [DW-1:0] sram_wr_data, sram_rd_data;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .m0_req(m0_req), .m0_ready(m0_ready), .m0_rd(m0_rd), .m0_addr(m0_addr),
    .m0_be(m0_be), .m0_wr_data(m0_wr_data), .m0_rd_data_vld(m0_rd_data_vld),
    .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_ready(m1_ready), .m1_rd(m1_rd), .m1_addr(m1_addr),
    .m1_be(m1_be), .m1_wr_data(m1_wr_data), .m1_rd_data_vld(m1_rd_data_vld),
    .m1_rd_data(m1_rd_data),
    .sram_req(sram_req), .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wr_data(sram_wr_data), .sram_ready(sram_ready),
    .sram_rd_data_vld(sram_rd_data_vld), .sram_rd_data(sram_rd_data),
    .grant_id(grant_id), .orphan_err(orphan_err)
  );

  typedef struct {
    logic          gid;
    logic          rd;
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [DW-1:0] wd;
  } cmd_t;
  typedef struct {
    logic          v0;
    logic          v1;
    logic [DW-1:0] d;
  } ret_t;
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } sram_ret_t;

  cmd_t      exp_cmd_q[$];
  ret_t      exp_ret_q[$];
  int        exp_rdy_q[$];
  sram_ret_t sram_q[$];
  cmd_t      cur;
  int        npass  = 0;
  int        ntotal = 0;
  int        cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge a_clk);
    #2;
  endtask

  task automatic push_cmd(input logic gid, input logic rd, input logic [AW-1:0] addr,
                          input logic [1:0] be, input logic [DW-1:0] wd);
    exp_cmd_q.push_back('{gid, rd, addr, be, wd});
  endtask

  // Waits for a command, holds it waitn cycles, pulses sram_ready once and,
  // for reads, schedules the SRAM return RDL cycles after the accept.
  task automatic serve(input int owner, input logic rd, input logic [DW-1:0] rdata,
                       input int waitn, input logic vld_exp, input logic drop);
    int n = 0;
    while (!sram_req && n < 50) begin
      tick();
      n++;
    end
    if (!sram_req) begin
      chk("sram_req_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (waitn) tick();
    sram_ready = 1'b1;
    exp_rdy_q.push_back(owner);
    if (rd) begin
      sram_q.push_back('{cyc + RDL, rdata});
      exp_ret_q.push_back('{vld_exp && owner == 0, vld_exp && owner == 1, rdata});
    end
    tick();
    sram_ready = 1'b0;
    if (drop) begin
      if (owner == 0) m0_req = 1'b0;
      else m1_req = 1'b0;
    end
  endtask

  // SRAM return model: drives read data in the cycle it falls due.
  initial begin
    sram_rd_data_vld = 1'b0;
    sram_rd_data     = '0;
    forever begin
      @(posedge a_clk);
      #1;
      cyc++;
      if (sram_q.size() > 0 && sram_q[0].due == cyc) begin
        sram_rd_data_vld = 1'b1;
        sram_rd_data     = sram_q[0].d;
        void'(sram_q.pop_front());
      end else begin
        sram_rd_data_vld = 1'b0;
        sram_rd_data     = '0;
      end
    end
  end

  // Monitor: compares on new commands, ready pulses and read returns.
  initial begin
    logic req_prev;
    int   e;
    req_prev = 1'b0;
    forever begin
      @(negedge a_clk);
      if (sram_req && !req_prev) begin
        if (exp_cmd_q.size() == 0) chk("unexpected_cmd", 32'd1, 32'd0);
        else begin
          cur = exp_cmd_q.pop_front();
          chk("cmd_grant_id", 32'(grant_id), 32'(cur.gid));
          chk("cmd_rd", 32'(sram_rd), 32'(cur.rd));
          chk("cmd_addr", 32'(sram_addr), 32'(cur.addr));
          chk("cmd_be", 32'(sram_be), 32'(cur.be));
          chk("cmd_wr_data", 32'(sram_wr_data), 32'(cur.wd));
        end
      end
      req_prev = sram_req;
      if (sram_ready) begin
        if (exp_rdy_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
        else begin
          e = exp_rdy_q.pop_front();
          chk("m0_ready", 32'(m0_ready), 32'(e == 0));
          chk("m1_ready", 32'(m1_ready), 32'(e == 1));
          chk("addr_stable_busy", 32'(sram_addr), 32'(cur.addr));
        end
      end else if (m0_ready || m1_ready) begin
        chk("spurious_ready", 32'({m1_ready, m0_ready}), 32'd0);
      end
      if (sram_rd_data_vld) begin
        if (exp_ret_q.size() == 0) chk("unexpected_return", 32'd1, 32'd0);
        else begin
          ret_t r;
          r = exp_ret_q.pop_front();
          chk("m0_rd_data_vld", 32'(m0_rd_data_vld), 32'(r.v0));
          chk("m1_rd_data_vld", 32'(m1_rd_data_vld), 32'(r.v1));
          chk("m0_rd_data", 32'(m0_rd_data), 32'(r.d));
          chk("m1_rd_data", 32'(m1_rd_data), 32'(r.d));
        end
      end else if (m0_rd_data_vld || m1_rd_data_vld) begin
        chk("spurious_rd_vld", 32'({m1_rd_data_vld, m0_rd_data_vld}), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    int seq[5] = '{0, 0, 0, 0, 1};
`else
    int seq[5] = '{0, 1, 0, 1, 1};
`endif
    a_rst = 1'b1; sram_ready = 1'b0;
    m0_req = 0; m0_rd = 0; m0_addr = '0; m0_be = '0; m0_wr_data = '0;
    m1_req = 0; m1_rd = 0; m1_addr = '0; m1_be = '0; m1_wr_data = '0;
    repeat (3) tick();
    a_rst = 1'b0;

    // Reset state
    chk("rst_sram_req", 32'(sram_req), 32'd0);
    chk("rst_sram_rd", 32'(sram_rd), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_be", 32'(sram_be), 32'd0);
    chk("rst_sram_wr_data", 32'(sram_wr_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_orphan_err", 32'(orphan_err), 32'd0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);

    // Single m0 read: one-cycle command latency, return to m0 only
    m0_rd = 1; m0_addr = 18'h00010; m0_be = 2'b11; m0_wr_data = '0; m0_req = 1;
    push_cmd(1'b0, 1'b1, 18'h00010, 2'b11, 16'h0000);
    tick();
    chk("req_latency", 32'(sram_req), 32'd1);
    serve(0, 1'b1, 16'hBEEF, 0, 1'b1, 1'b1);
    repeat (8) tick();

    // Contention, both requesting continuously from a fresh reset
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    a0 = 18'h00100; a1 = 18'h00200; d0 = 16'h1111; d1 = 16'h2222;
    m0_rd = 0; m0_be = 2'b11; m0_addr = a0; m0_wr_data = d0;
    m1_rd = 0; m1_be = 2'b11; m1_addr = a1; m1_wr_data = d1;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 5; k++) begin
      int id;
      id = seq[k];
      if (id == 0) push_cmd(1'b0, 1'b0, a0, 2'b11, d0);
      else push_cmd(1'b1, 1'b0, a1, 2'b11, d1);
      serve(id, 1'b0, 16'h0000, 0, 1'b0, k == 4);
      if (id == 0) begin a0 = a0 + 1; d0 = d0 + 1; m0_addr = a0; m0_wr_data = d0; end
      else begin a1 = a1 + 1; d1 = d1 + 1; m1_addr = a1; m1_wr_data = d1; end
      if (k == 3) m0_req = 0;
    end
    repeat (3) tick();

    // m1 write at the top address, partial byte enable, no return
    m1_rd = 0; m1_addr = 18'h3FFFF; m1_be = 2'b01; m1_wr_data = 16'hA5A5; m1_req = 1;
    push_cmd(1'b1, 1'b0, 18'h3FFFF, 2'b01, 16'hA5A5);
    serve(1, 1'b0, 16'h0000, 1, 1'b0, 1'b1);
    repeat (6) tick();

    // Back-to-back reads m0 then m1, returns routed in order
    m0_rd = 1; m0_addr = 18'h00020; m0_be = 2'b11; m0_wr_data = '0;
    m1_rd = 1; m1_addr = 18'h00030; m1_be = 2'b11; m1_wr_data = '0;
    m0_req = 1; m1_req = 1;
    push_cmd(1'b0, 1'b1, 18'h00020, 2'b11, 16'h0000);
    push_cmd(1'b1, 1'b1, 18'h00030, 2'b11, 16'h0000);
    serve(0, 1'b1, 16'h0A0A, 2, 1'b1, 1'b1);
    serve(1, 1'b1, 16'h0B0B, 2, 1'b1, 1'b1);
    repeat (10) tick();
    chk("b2b_orphan_err", 32'(orphan_err), 32'd0);

    // Return with empty tag pipeline: dropped, orphan_err sticks until reset
    sram_q.push_back('{cyc + 1, 16'hDEAD});
    exp_ret_q.push_back('{1'b0, 1'b0, 16'hDEAD});
    repeat (3) tick();
    chk("orphan_set", 32'(orphan_err), 32'd1);
    repeat (5) tick();
    chk("orphan_sticky", 32'(orphan_err), 32'd1);
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    chk("orphan_cleared", 32'(orphan_err), 32'd0);

    // Reset while BUSY with an earlier read still in flight
    m0_rd = 1; m0_addr = 18'h00040; m0_be = 2'b11; m0_req = 1;
    push_cmd(1'b0, 1'b1, 18'h00040, 2'b11, 16'h0000);
    serve(0, 1'b1, 16'h4444, 0, 1'b0, 1'b1);
    m1_rd = 1; m1_addr = 18'h00050; m1_be = 2'b11; m1_wr_data = '0; m1_req = 1;
    push_cmd(1'b1, 1'b1, 18'h00050, 2'b11, 16'h0000);
    tick();
    chk("busy_before_rst", 32'(sram_req), 32'd1);
    a_rst = 1'b1; m1_req = 0;
    tick();
    a_rst = 1'b0;
    chk("req_after_rst", 32'(sram_req), 32'd0);
    repeat (4) tick();
    chk("orphan_after_rst", 32'(orphan_err), 32'd1);

    repeat (5) tick();
    chk("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk("rdy_q_drained", 32'(exp_rdy_q.size()), 32'd0);
    chk("ret_q_drained", 32'(exp_ret_q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
